frame_scanner: RTL and testbench

- Read-side companion to the frame buffer. The frame buffer accepts FrameIn bytes and serves a 300x100 cropped window through readFrame/FrameWInd/FrameDataOut.
- This block is the reader: a raster timing generator that walks the visible window in line order, issues readFrame with a linear FrameWInd, and captures the returned byte.
- It emits a pixel stream with horizontal/vertical sync and blanking for the downstream display adapter.

---
 rtl/frame_scanner.sv | 190 +++++++++++++++++++
 tb/tb_frame_scanner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/frame_scanner.sv
// frame_scanner: raster timing generator that reads a cropped frame window
// out of the frame buffer and turns it into a display pixel stream.
//
// The scan walks H_TOTAL x V_TOTAL positions. Only the H_ACTIVE x V_ACTIVE
// visible area issues reads. Each read fetches one byte at a linear index.
// The byte comes back one edge later and is presented on PixelData one edge
// after that.
//
// Ports:
//   clk         in   1   sole clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   Enable      in   1   scanning permitted while high
//   FrameReady  in   1   frame buffer holds a complete frame
//   FrameDataIn in   8   byte returned by the frame buffer
//   readFrame   out  1   read strobe to the frame buffer
//   FrameWInd   out  16  linear read index (line*H_ACTIVE + px)
//   PxOut       out  10  horizontal counter
//   LineOut     out  10  vertical counter
//   HSync       out  1   active-high horizontal sync
//   VSync       out  1   active-high vertical sync
//   PixelValid  out  1   PixelData holds a visible pixel
//   PixelData   out  8   captured pixel byte
//   FrameDone   out  1   one-cycle pulse on the last cycle of a frame
//
// The parameters must satisfy H_TOTAL, V_TOTAL <= 1024 because the counters
// are 10 bits wide. They must also satisfy H_ACTIVE*V_ACTIVE <= 65536
// because the index is 16 bits wide.

module frame_scanner #(
  parameter int H_ACTIVE = 300,
  parameter int H_FRONT  = 10,
  parameter int H_SYNC   = 20,
  parameter int H_BACK   = 10,
  parameter int V_ACTIVE = 100,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Enable,
  input  logic        FrameReady,
  input  logic [7:0]  FrameDataIn,
  output logic        readFrame,
  output logic [15:0] FrameWInd,
  output logic [9:0]  PxOut,
  output logic [9:0]  LineOut,
  output logic        HSync,
  output logic        VSync,
  output logic        PixelValid,
  output logic [7:0]  PixelData,
  output logic        FrameDone
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  line_q, line_d;
  logic [15:0] wind_q, wind_d;
  logic        rd_d1_q;
  logic        pix_valid_q;
  logic [7:0]  pix_data_q;

  logic in_scan_s;
  logic line_end_s;
  logic frame_end_s;
  logic rd_s;

  assign in_scan_s   = (state_q == SCAN);
  assign line_end_s  = (px_q == H_LAST);
  assign frame_end_s = in_scan_s && line_end_s && (line_q == V_LAST);

  // Read strobe and sync windows are decoded from the registered counters,
  // so they are glitch-free and all read zero in IDLE and under reset.
  assign rd_s = in_scan_s && (px_q < H_ACT) && (line_q < V_ACT);

  assign readFrame  = rd_s;
  assign HSync      = in_scan_s && (px_q >= HS_START) && (px_q < HS_END);
  assign VSync      = in_scan_s && (line_q >= VS_START) && (line_q < VS_END);
  assign FrameDone  = frame_end_s;
  assign PxOut      = px_q;
  assign LineOut    = line_q;
  assign FrameWInd  = wind_q;
  assign PixelValid = pix_valid_q;
  assign PixelData  = pix_data_q;

  // Next-state logic for the scan FSM, the raster counters and the read index.
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    line_d  = line_q;
    wind_d  = wind_q;
    case (state_q)
      IDLE: begin
        px_d   = 10'd0;
        line_d = 10'd0;
        wind_d = 16'd0;
        if (Enable && FrameReady) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (frame_end_s) begin
          // A frame always completes; the inputs are consulted only here.
          px_d   = 10'd0;
          line_d = 10'd0;
          wind_d = 16'd0;
          if (Enable && FrameReady) begin
            state_d = SCAN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (line_end_s) begin
            px_d   = 10'd0;
            line_d = line_q + 10'd1;
          end else begin
            px_d   = px_q + 10'd1;
            line_d = line_q;
          end
          // The index advances once per read instead of being computed with
          // a multiply. It keeps equal to line*H_ACTIVE + px in the visible
          // area because each visible line issues exactly H_ACTIVE reads.
          if (rd_s) begin
            wind_d = wind_q + 16'd1;
          end else begin
            wind_d = wind_q;
          end
          state_d = SCAN;
        end
      end
      default: begin
        state_d = IDLE;
        px_d    = 10'd0;
        line_d  = 10'd0;
        wind_d  = 16'd0;
      end
    endcase
  end

  // State, counter and index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      px_q    <= 10'd0;
      line_q  <= 10'd0;
      wind_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      line_q  <= line_d;
      wind_q  <= wind_d;
    end
  end

  // Read-return pipeline. The frame buffer answers one edge after the
  // strobe, and the byte is captured on the following edge. This pipeline
  // keeps running in IDLE so the final reads of a frame still drain out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_d1_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 8'd0;
    end else begin
      rd_d1_q     <= rd_s;
      pix_valid_q <= rd_d1_q;
      if (rd_d1_q) begin
        pix_data_q <= FrameDataIn;
      end else begin
        pix_data_q <= pix_data_q;
      end
    end
  end

endmodule

// File: tb/tb_frame_scanner.sv
// Self-checking bench for frame_scanner.
//
// A frame-buffer model answers every read with the low byte of the
// requested index, one edge after the request. A scoreboard queue records
// each read together with the cycle in which its pixel must appear. Raster
// counters, sync windows, read strobe, index and FrameDone are compared
// every cycle against a position model derived from the frame cycle number.

module tb_frame_scanner;

  logic        clk;
  logic        reset;
  logic        Enable;
  logic        FrameReady;
  logic [7:0]  FrameDataIn;
  logic        readFrame;
  logic [15:0] FrameWInd;
  logic [9:0]  PxOut;
  logic [9:0]  LineOut;
  logic        HSync;
  logic        VSync;
  logic        PixelValid;
  logic [7:0]  PixelData;
  logic        FrameDone;

  frame_scanner dut (
    .clk        (clk),
    .reset      (reset),
    .Enable     (Enable),
    .FrameReady (FrameReady),
    .FrameDataIn(FrameDataIn),
    .readFrame  (readFrame),
    .FrameWInd  (FrameWInd),
    .PxOut      (PxOut),
    .LineOut    (LineOut),
    .HSync      (HSync),
    .VSync      (VSync),
    .PixelValid (PixelValid),
    .PixelData  (PixelData),
    .FrameDone  (FrameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer model: registers the requested byte one edge after readFrame.
  always @(posedge clk) begin
    if (readFrame) FrameDataIn <= FrameWInd[7:0];
  end

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    cyc++;
  endtask

  // Scoreboard: push each read, and pop plus compare on each valid pixel.
  task automatic sb_step();
    exp_t e;
    if (PixelValid) begin
      n_valid++;
      if (q.size() == 0) begin
        chk("sb_unexpected_pixel", 32'(1), 32'(0));
      end else begin
        e = q.pop_front();
        chk("pix_data", 32'(PixelData), 32'(e.data));
        chk("pix_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (readFrame) begin
      e.data = FrameWInd[7:0];
      e.due  = cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"},    32'(readFrame),  32'(0));
    chk({tag, "_wind"},  32'(FrameWInd),  32'(0));
    chk({tag, "_px"},    32'(PxOut),      32'(0));
    chk({tag, "_line"},  32'(LineOut),    32'(0));
    chk({tag, "_hs"},    32'(HSync),      32'(0));
    chk({tag, "_vs"},    32'(VSync),      32'(0));
    chk({tag, "_valid"}, 32'(PixelValid), 32'(0));
    chk({tag, "_data"},  32'(PixelData),  32'(0));
    chk({tag, "_done"},  32'(FrameDone),  32'(0));
  endtask

  task automatic tick_idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      chk("idle_rd",   32'(readFrame), 32'(0));
      chk("idle_px",   32'(PxOut),     32'(0));
      chk("idle_line", 32'(LineOut),   32'(0));
      chk("idle_hs",   32'(HSync),     32'(0));
      chk("idle_vs",   32'(VSync),     32'(0));
      chk("idle_done", 32'(FrameDone), 32'(0));
      chk("idle_wind", 32'(FrameWInd), 32'(0));
      sb_step();
    end
  endtask

  // Follows n cycles of a frame starting at its first SCAN cycle. When
  // drop_line >= 0, Enable is dropped at the start of that line.
  task automatic run_frame(input int drop_line, input int n);
    int px, ln, reads, hs_cnt, vs_cnt, valid0;
    logic act;
    reads = 0; hs_cnt = 0; vs_cnt = 0; valid0 = n_valid;
    for (int k = 0; k < n; k++) begin
      sample();
      px  = k % 340;
      ln  = k / 340;
      act = (px < 300) && (ln < 100);
      chk("px",   32'(PxOut),     32'(px));
      chk("line", 32'(LineOut),   32'(ln));
      chk("rd",   32'(readFrame), 32'(act));
      chk("hs",   32'(HSync),     32'((px >= 310) && (px < 330)));
      chk("vs",   32'(VSync),     32'((ln >= 102) && (ln < 105)));
      chk("done", 32'(FrameDone), 32'(k == 37399));
      if (act) chk("wind", 32'(FrameWInd), 32'(ln * 300 + px));
      if (readFrame) reads++;
      if (HSync) hs_cnt++;
      if (VSync) vs_cnt++;
      sb_step();
      if (ln == drop_line && px == 0) Enable = 1'b0;
    end
    if (n == 37400) begin
      chk("frame_reads",  32'(reads),             32'(30000));
      chk("frame_hs_cyc", 32'(hs_cnt),            32'(20 * 110));
      chk("frame_vs_cyc", 32'(vs_cnt),            32'(1020));
      chk("frame_valids", 32'(n_valid - valid0),  32'(30000));
    end
  endtask

  initial begin
    reset       = 1'b0;
    Enable      = 1'b0;
    FrameReady  = 1'b0;
    FrameDataIn = 8'd0;

    // Reset state.
    sample();
    sample();
    chk_zero("reset");

    // Enabled but no frame available: stays idle.
    reset  = 1'b1;
    Enable = 1'b1;
    tick_idle(100);

    // Frame 1 and then frame 2, back to back. Frame 2 drops Enable at line 50.
    FrameReady = 1'b1;
    @(posedge clk);
    run_frame(-1, 37400);
    run_frame(50, 37400);
    tick_idle(10);
    chk("sb_drained", 32'(q.size()), 32'(0));

    // Restart, then apply an asynchronous reset mid-line (px 150, line 20).
    Enable = 1'b1;
    @(posedge clk);
    run_frame(-1, 20 * 340 + 151);
    chk("pre_reset_px",   32'(PxOut),   32'(150));
    chk("pre_reset_line", 32'(LineOut), 32'(20));
    #1 reset = 1'b0;
    #1 chk_zero("async_reset");
    q.delete();
    @(negedge clk);
    reset = 1'b1;

    // After release, the scan restarts from index 0.
    @(posedge clk);
    run_frame(-1, 700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
